board_cursor_ctrl: RTL and testbench
====================================

Name: board_cursor_ctrl

Overview:
Parametrised cursor and selection controller for the board UI, driven by the five push-buttons. Generalises fixed 8x8 cursor movement to ROW_BITS x COL_BITS boards, with optional edge wrap, hold-to-repeat and a two-step select/destination state machine. Hands a from/to move request to the game logic over a req/done handshake, and drives the cursor and highlight outputs to the VGA/board renderer.

Parameters:
ROW_BITS, 3, row index width; board has 2**ROW_BITS rows, row 0 = top rank
COL_BITS, 3, column index width; 2**COL_BITS columns, col 0 = file a
INIT_ROW, 6, cursor row after reset (e2 with defaults)
INIT_COL, 4, cursor column after reset
WRAP, 0, 0 = saturate at edges, 1 = wrap to opposite edge
REPEAT_DELAY, 25_000_000, cycles a direction button is held before the first auto-repeat step
REPEAT_PERIOD, 5_000_000, cycles between later auto-repeat steps; 0 disables auto-repeat

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BtnU  in  1  synchronised, debounced level; move up (row-1)
BtnD  in  1  move down (row+1)
BtnL  in  1  move left (col-1)
BtnR  in  1  move right (col+1)
BtnC  in  1  select / confirm
cursor_owned  in  1  comb. from game logic: square at cursor_addr holds side-to-move's piece
move_done  in  1  one-cycle ack from game logic; move processed (legal or not)
cursor_addr  out  ROW_BITS+COL_BITS  {row,col} of cursor
selected_piece_addr  out  ROW_BITS+COL_BITS  latched source square
hilite_selected_square  out  1  source square is currently selected
move_req  out  1  move request pending
move_from  out  ROW_BITS+COL_BITS  source of pending request
move_to  out  ROW_BITS+COL_BITS  destination of pending request
busy  out  1  high in WAIT_DONE

Behaviour:
- Reset (RESET=0, async): cursor_addr={INIT_ROW,INIT_COL}; selected_piece_addr=0; hilite=0; move_req=0; move_from=move_to=0; busy=0; state SEL_SRC; repeat counter=0; button history regs=0.
- Edge detect: each button has a history register. A press = current 1 with history 0. The action takes effect at the first CLK edge where the button samples 1; outputs change that edge (0-cycle latency after sampling).
- Direction priority when several press/repeat events fire in one cycle: U > D > L > R. Exactly one step per cycle.
- Step, WRAP=0: at row 0 an up step leaves the cursor unchanged; at row max a down step leaves it unchanged; columns behave the same way.
- Step, WRAP=1: modular arithmetic on the index width.
- Auto-repeat: while the winning direction button stays high, the counter counts from its press. One step at REPEAT_DELAY, then one step every REPEAT_PERIOD. The counter clears on release or when the winning direction changes.
- Movement is allowed in every state, including WAIT_DONE.
- FSM:
  - SEL_SRC: BtnC press with cursor_owned=1 latches selected_piece_addr=cursor_addr, sets hilite=1, goes to SEL_DST. BtnC with cursor_owned=0 is ignored.
  - SEL_DST: BtnC press on the same square clears hilite and returns to SEL_SRC. BtnC on another owned square re-latches the source and stays in SEL_DST. BtnC on any other square loads move_from=selected_piece_addr and move_to=cursor_addr, sets move_req=1 and busy=1, and goes to WAIT_DONE.
  - WAIT_DONE: move_req, move_from and move_to stay stable. BtnC is ignored. When move_done=1: next edge clears move_req, busy and hilite, and returns to SEL_SRC.
- A move_done seen outside WAIT_DONE is ignored.
- BtnC and a direction event in the same cycle: the select action uses the pre-step cursor_addr.
- Reset mid-operation: any pending move_req is dropped immediately (async); the game logic must treat reset as an abort.

Decomposition:
- Shared package chess_defs holds the PIECE_*/COLOR_* constants, FSM state encodings (SEL_SRC=2'd0, SEL_DST=2'd1, WAIT_DONE=2'd2) and a square-address width macro.
- Natural sub-module: btn_repeat (edge detect plus hold-repeat counter, parametrised by REPEAT_DELAY/REPEAT_PERIOD). One instance per direction; the top module does priority and FSM.

Test Plan:
1. Defaults, WRAP=0: D,D,L×5,U×8,R×8 single presses → cursor_addr=6'b000_111; the extra D/L/U/R presses at edges leave the cursor unchanged.
2. WRAP=1, ROW_BITS=2, COL_BITS=2: from reset with INIT=(1,1), L,L → col=3; U,U → row=3; cursor_addr=4'b11_11.
3. REPEAT_DELAY=10, REPEAT_PERIOD=4: hold BtnR 30 cycles from col 0 → steps at press, +10, +14, +18, +22, +26 → col=6.
4. cursor_owned=1 at 6'b110_100, BtnC → hilite=1, selected=6'b110_100. Move U,U, cursor_owned=0, BtnC → move_req=1, from=6'b110_100, to=6'b100_100. Pulse move_done → next edge move_req=0, hilite=0, state SEL_SRC.
5. In SEL_DST, BtnC on the source square → hilite=0, no move_req. Reselect on another owned square → selected updates, still SEL_DST.
6. With move_req=1, assert RESET=0 mid-cycle → move_req=0 and cursor=INIT immediately, before the next CLK edge. In WAIT_DONE, extra BtnC presses produce no change.

Source files
------------

// File: rtl/board_cursor_ctrl_pkg.sv
// Shared board/UI definitions: piece and colour codes, selection FSM states,
// and the square-address width helper used by the cursor controller.
package board_cursor_ctrl_pkg;

  localparam logic [2:0] PIECE_EMPTY  = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [1:0] {
    SEL_SRC   = 2'd0,
    SEL_DST   = 2'd1,
    WAIT_DONE = 2'd2
  } sel_state_t;

  function automatic int unsigned sq_addr_w(input int unsigned row_bits,
                                            input int unsigned col_bits);
    return row_bits + col_bits;
  endfunction

endpackage

// File: rtl/board_cursor_ctrl_btn_repeat.sv
// Per-button edge detector plus hold-to-repeat timer; step is combinational so
// the action lands on the same edge that first samples the button high.
module board_cursor_ctrl_btn_repeat #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  input  logic winner,
  output logic press,
  output logic step
);

  localparam int unsigned MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = $clog2(MAXV + 1) + 1;
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);

  logic          hist;
  logic          first;
  logic [CW-1:0] cnt;
  logic          rpt;
  logic          active;

  assign press  = btn & ~hist;
  assign active = btn & winner & (REPEAT_PERIOD != 0);

  always_comb begin
    rpt = 1'b0;
    if (active && !press) begin
      rpt = first ? (cnt == DLY) : (cnt == PER);
    end
  end

  assign step = press | rpt;

  // cnt holds the number of cycles since this button became the held winner,
  // restarted at each repeat step; a non-winner is held at zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hist  <= 1'b0;
      first <= 1'b1;
      cnt   <= '0;
    end else begin
      hist <= btn;
      if (!active) begin
        cnt   <= '0;
        first <= 1'b1;
      end else if (rpt) begin
        cnt   <= CW'(1);
        first <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_cursor_ctrl.sv
// Board cursor and two-step selection controller: moves the cursor from the
// direction buttons and issues from/to move requests over a req/done handshake.
module board_cursor_ctrl
  import board_cursor_ctrl_pkg::*;
#(
  parameter int unsigned ROW_BITS      = 3,
  parameter int unsigned COL_BITS      = 3,
  parameter int unsigned INIT_ROW      = 6,
  parameter int unsigned INIT_COL      = 4,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         BtnU,
  input  logic                         BtnD,
  input  logic                         BtnL,
  input  logic                         BtnR,
  input  logic                         BtnC,
  input  logic                         cursor_owned,
  input  logic                         move_done,
  output logic [ROW_BITS+COL_BITS-1:0] cursor_addr,
  output logic [ROW_BITS+COL_BITS-1:0] selected_piece_addr,
  output logic                         hilite_selected_square,
  output logic                         move_req,
  output logic [ROW_BITS+COL_BITS-1:0] move_from,
  output logic [ROW_BITS+COL_BITS-1:0] move_to,
  output logic                         busy
);

  localparam int unsigned AW = sq_addr_w(ROW_BITS, COL_BITS);
  localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
  localparam logic [COL_BITS-1:0] COL_MAX = '1;

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [AW-1:0]       cur;
  logic                win_u, win_d, win_l, win_r;
  logic                step_u, step_d, step_l, step_r;
  logic                press_u, press_d, press_l, press_r;
  logic                c_hist;
  logic                c_press;
  sel_state_t          state;

  assign cur         = {row, col};
  assign cursor_addr = cur;
  assign c_press     = BtnC & ~c_hist;

  // Repeat timing follows the highest-priority button that is held.
  assign win_u = BtnU;
  assign win_d = BtnD & ~BtnU;
  assign win_l = BtnL & ~BtnU & ~BtnD;
  assign win_r = BtnR & ~BtnU & ~BtnD & ~BtnL;

  board_cursor_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_u (
    .CLK(CLK), .RESET(RESET), .btn(BtnU), .winner(win_u), .press(press_u), .step(step_u)
  );
  board_cursor_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_d (
    .CLK(CLK), .RESET(RESET), .btn(BtnD), .winner(win_d), .press(press_d), .step(step_d)
  );
  board_cursor_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_l (
    .CLK(CLK), .RESET(RESET), .btn(BtnL), .winner(win_l), .press(press_l), .step(step_l)
  );
  board_cursor_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_r (
    .CLK(CLK), .RESET(RESET), .btn(BtnR), .winner(win_r), .press(press_r), .step(step_r)
  );

  logic unused_press;
  assign unused_press = press_u ^ press_d ^ press_l ^ press_r;

  // One step per cycle, U > D > L > R; edges saturate unless WRAP is set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row <= ROW_BITS'(INIT_ROW);
      col <= COL_BITS'(INIT_COL);
    end else if (step_u) begin
      if (row != '0 || WRAP != 0) row <= row - 1'b1;
    end else if (step_d) begin
      if (row != ROW_MAX || WRAP != 0) row <= row + 1'b1;
    end else if (step_l) begin
      if (col != '0 || WRAP != 0) col <= col - 1'b1;
    end else if (step_r) begin
      if (col != COL_MAX || WRAP != 0) col <= col + 1'b1;
    end
  end

  // Selection uses cur, the pre-step address, when BtnC coincides with a move.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state                  <= SEL_SRC;
      c_hist                 <= 1'b0;
      selected_piece_addr    <= '0;
      hilite_selected_square <= 1'b0;
      move_req               <= 1'b0;
      move_from              <= '0;
      move_to                <= '0;
      busy                   <= 1'b0;
    end else begin
      c_hist <= BtnC;
      case (state)
        SEL_SRC: begin
          if (c_press && cursor_owned) begin
            selected_piece_addr    <= cur;
            hilite_selected_square <= 1'b1;
            state                  <= SEL_DST;
          end
        end
        SEL_DST: begin
          if (c_press) begin
            if (cur == selected_piece_addr) begin
              hilite_selected_square <= 1'b0;
              state                  <= SEL_SRC;
            end else if (cursor_owned) begin
              selected_piece_addr <= cur;
            end else begin
              move_from <= selected_piece_addr;
              move_to   <= cur;
              move_req  <= 1'b1;
              busy      <= 1'b1;
              state     <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (move_done) begin
            move_req               <= 1'b0;
            busy                   <= 1'b0;
            hilite_selected_square <= 1'b0;
            state                  <= SEL_SRC;
          end
        end
        default: state <= SEL_SRC;
      endcase
    end
  end

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Bench for board_cursor_ctrl: two configurations driven in lockstep and
// compared every cycle against a behavioural model of the cursor/selection rules.
module tb_board_cursor_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic bu = 0, bd = 0, bl = 0, br = 0, bc = 0, done = 0;
  logic own_a, own_b;

  logic [5:0] ca, sa, fa, ta;
  logic       ha, ra, ya;
  logic [3:0] cb_, sb, fb, tb;
  logic       hb, rb_, yb;

  bit own_map_a[64];
  bit own_map_b[16];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign own_a = own_map_a[ca];
  assign own_b = own_map_b[cb_];

  board_cursor_ctrl #(
    .ROW_BITS(3), .COL_BITS(3), .INIT_ROW(6), .INIT_COL(4), .WRAP(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut_a (
    .CLK(clk), .RESET(rst_n), .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br), .BtnC(bc),
    .cursor_owned(own_a), .move_done(done), .cursor_addr(ca), .selected_piece_addr(sa),
    .hilite_selected_square(ha), .move_req(ra), .move_from(fa), .move_to(ta), .busy(ya)
  );

  board_cursor_ctrl #(
    .ROW_BITS(2), .COL_BITS(2), .INIT_ROW(1), .INIT_COL(1), .WRAP(1),
    .REPEAT_DELAY(5), .REPEAT_PERIOD(0)
  ) dut_b (
    .CLK(clk), .RESET(rst_n), .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br), .BtnC(bc),
    .cursor_owned(own_b), .move_done(done), .cursor_addr(cb_), .selected_piece_addr(sb),
    .hilite_selected_square(hb), .move_req(rb_), .move_from(fb), .move_to(tb), .busy(yb)
  );

  // Model configuration per board: 0 = 8x8 saturating, 1 = 4x4 wrapping.
  int rbits[2] = '{3, 2};
  int cbits[2] = '{3, 2};
  int wrapc[2] = '{0, 1};
  int dly[2]   = '{10, 5};
  int per[2]   = '{4, 0};
  int irow[2]  = '{6, 1};
  int icol[2]  = '{4, 1};

  // Model state: phase 0 = choosing source, 1 = source chosen, 2 = awaiting ack.
  int m_row[2], m_col[2], m_win[2], m_held[2], m_ph[2];
  int m_sel[2], m_hil[2], m_req[2], m_from[2], m_to[2];
  bit [3:0] prev_b;
  bit       prev_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_row[i] = irow[i]; m_col[i] = icol[i];
      m_win[i] = -1; m_held[i] = 0; m_ph[i] = 0;
      m_sel[i] = 0; m_hil[i] = 0; m_req[i] = 0; m_from[i] = 0; m_to[i] = 0;
    end
    prev_b = '0;
    prev_c = 1'b0;
  endtask

  task automatic model_dut(input int i, input bit [3:0] b, input bit [3:0] pr, input bit cp);
    int win, ev, addr, rmax, cmax;
    bit rpt, owned;
    rmax = (1 << rbits[i]) - 1;
    cmax = (1 << cbits[i]) - 1;
    win = -1;
    for (int d = 0; d < 4; d++) if (b[d] && win < 0) win = d;
    if (win >= 0 && win == m_win[i]) m_held[i]++;
    else m_held[i] = 0;
    m_win[i] = win;
    rpt = (win >= 0) && (per[i] > 0) &&
          (m_held[i] == dly[i] || (m_held[i] > dly[i] && (m_held[i] - dly[i]) % per[i] == 0));
    ev = -1;
    for (int d = 0; d < 4; d++) if ((pr[d] || (d == win && rpt)) && ev < 0) ev = d;
    addr  = m_row[i] * (cmax + 1) + m_col[i];
    owned = (i == 0) ? own_map_a[addr] : own_map_b[addr];
    if (m_ph[i] == 0) begin
      if (cp && owned) begin m_sel[i] = addr; m_hil[i] = 1; m_ph[i] = 1; end
    end else if (m_ph[i] == 1) begin
      if (cp) begin
        if (addr == m_sel[i]) begin m_hil[i] = 0; m_ph[i] = 0; end
        else if (owned) m_sel[i] = addr;
        else begin m_from[i] = m_sel[i]; m_to[i] = addr; m_req[i] = 1; m_ph[i] = 2; end
      end
    end else begin
      if (done) begin m_req[i] = 0; m_hil[i] = 0; m_ph[i] = 0; end
    end
    case (ev)
      0: if (m_row[i] > 0) m_row[i]--; else if (wrapc[i] != 0) m_row[i] = rmax;
      1: if (m_row[i] < rmax) m_row[i]++; else if (wrapc[i] != 0) m_row[i] = 0;
      2: if (m_col[i] > 0) m_col[i]--; else if (wrapc[i] != 0) m_col[i] = cmax;
      3: if (m_col[i] < cmax) m_col[i]++; else if (wrapc[i] != 0) m_col[i] = 0;
      default: ;
    endcase
  endtask

  task automatic model_cycle();
    bit [3:0] b;
    b = {br, bl, bd, bu};
    for (int i = 0; i < 2; i++) model_dut(i, b, b & ~prev_b, bc && !prev_c);
    prev_b = b;
    prev_c = bc;
  endtask

  task automatic compare_all();
    check_eq("a_cursor", ca, m_row[0] * 8 + m_col[0]);
    check_eq("a_sel",    sa, m_sel[0]);
    check_eq("a_hilite", ha, m_hil[0]);
    check_eq("a_req",    ra, m_req[0]);
    check_eq("a_from",   fa, m_from[0]);
    check_eq("a_to",     ta, m_to[0]);
    check_eq("a_busy",   ya, m_ph[0] == 2);
    check_eq("b_cursor", cb_, m_row[1] * 4 + m_col[1]);
    check_eq("b_sel",    sb, m_sel[1]);
    check_eq("b_hilite", hb, m_hil[1]);
    check_eq("b_req",    rb_, m_req[1]);
    check_eq("b_from",   fb, m_from[1]);
    check_eq("b_to",     tb, m_to[1]);
    check_eq("b_busy",   yb, m_ph[1] == 2);
  endtask

  // Called just after a falling edge: drive, advance model, check after the rising edge.
  task automatic cyc(input bit u, input bit d, input bit l, input bit r, input bit c, input bit dn);
    bu = u; bd = d; bl = l; br = r; bc = c; done = dn;
    model_cycle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int dir);
    cyc(dir == 0, dir == 1, dir == 2, dir == 3, dir == 4, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic hard_reset();
    bu = 0; bd = 0; bl = 0; br = 0; bc = 0; done = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req_a", ra, 0);
    check_eq("rst_async_req_b", rb_, 0);
    check_eq("rst_async_busy_a", ya, 0);
    check_eq("rst_async_cur_a", ca, 6'b110_100);
    check_eq("rst_async_cur_b", cb_, 4'b01_01);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bit [3:0] dirs;
    int n, pick;
    bit dn;
    model_reset();
    @(negedge clk);
    hard_reset();

    // Saturating walk into the top-right corner.
    press(1); press(1);
    for (int k = 0; k < 5; k++) press(2);
    for (int k = 0; k < 8; k++) press(0);
    for (int k = 0; k < 8; k++) press(3);
    check_eq("p1_corner", ca, 6'b000_111);

    // Wrapping board from (1,1).
    hard_reset();
    press(2); press(2); press(0); press(0);
    check_eq("p2_wrap", cb_, 4'b11_11);

    // Hold-to-repeat from column 0.
    hard_reset();
    for (int k = 0; k < 4; k++) press(2);
    for (int k = 0; k < 30; k++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("p3_repeat", ca, 6'b110_110);

    // Select, move request, stable while waiting, ack.
    hard_reset();
    own_map_a[6'b110_100] = 1'b1;
    press(4);
    check_eq("p4_hilite", ha, 1);
    check_eq("p4_sel", sa, 6'b110_100);
    press(0); press(0); press(4);
    check_eq("p4_req", ra, 1);
    check_eq("p4_from", fa, 6'b110_100);
    check_eq("p4_to", ta, 6'b100_100);
    press(4); press(3); press(4);
    check_eq("p6_req_hold", ra, 1);
    check_eq("p6_to_hold", ta, 6'b100_100);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("p4_done_req", ra, 0);
    check_eq("p4_done_hil", ha, 0);
    check_eq("p4_done_busy", ya, 0);

    // Deselect, reselect, then reset with a request pending.
    hard_reset();
    own_map_a[6'b110_101] = 1'b1;
    press(4); press(4);
    check_eq("p5_desel_hil", ha, 0);
    check_eq("p5_desel_req", ra, 0);
    press(4); press(3); press(4);
    check_eq("p5_resel", sa, 6'b110_101);
    check_eq("p5_still_hil", ha, 1);
    press(2); press(0); press(4);
    check_eq("p6_req_set", ra, 1);
    hard_reset();

    // Randomised traffic.
    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 64; k++) own_map_a[k] = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 16; k++) own_map_b[k] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 29) == 0) hard_reset();
      pick = $urandom_range(0, 5);
      if (pick < 4) dirs = 4'(1 << pick);
      else if (pick == 4) dirs = 4'($urandom_range(0, 15));
      else dirs = '0;
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        if (m_ph[0] == 2 || m_ph[1] == 2) dn = ($urandom_range(0, 3) == 0);
        else dn = ($urandom_range(0, 15) == 0);
        cyc(dirs[0], dirs[1], dirs[2], dirs[3], $urandom_range(0, 5) == 0, dn);
      end
      cyc(0, 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
